cv32e40p_hwloop_regs_gen: RTL

//   Parametrised hardware-loop register file: N_REGS sets of start/end/counter.

---
 rtl/cv32e40p_hwloop_regs_gen_if.sv | 54 +++++
 rtl/cv32e40p_hwloop_regs_gen.sv | 112 +++++++++++
 2 files changed

// File: rtl/cv32e40p_hwloop_regs_gen_if.sv
`default_nettype none
// ============================================================================
//  Module   : cv32e40p_hwloop_regs_gen_if
//  Purpose  : Bundle of setup, decrement, CSR-read and loop-state signals
//             between the EX-stage hwloop path and the loop register file.
//  Revision : 1.0  initial release
// ============================================================================
interface cv32e40p_hwloop_regs_gen_if #(
  parameter int N_REGS     = 2,
  parameter int N_REG_BITS = (N_REGS > 1) ? $clog2(N_REGS) : 1,
  parameter int ADDR_WIDTH = 32,
  parameter int CNT_WIDTH  = 32
) ();

  logic                                  setback_i;
  logic [ADDR_WIDTH-1:0]                 hwlp_start_data_i;
  logic [ADDR_WIDTH-1:0]                 hwlp_end_data_i;
  logic [CNT_WIDTH-1:0]                  hwlp_cnt_data_i;
  logic [2:0]                            hwlp_we_i;
  logic [N_REG_BITS-1:0]                 hwlp_regid_i;
  logic                                  valid_i;
  logic [N_REGS-1:0]                     hwlp_dec_cnt_i;
  logic                                  rd_req_i;
  logic [N_REG_BITS-1:0]                 rd_regid_i;
  logic [1:0]                            rd_sel_i;
  logic [31:0]                           rd_data_o;
  logic                                  rd_valid_o;
  logic [N_REGS-1:0][ADDR_WIDTH-1:0]     hwlp_start_addr_o;
  logic [N_REGS-1:0][ADDR_WIDTH-1:0]     hwlp_end_addr_o;
  logic [N_REGS-1:0][CNT_WIDTH-1:0]      hwlp_counter_o;
  logic [N_REGS-1:0]                     hwlp_active_o;
  logic [N_REGS-1:0]                     hwlp_done_o;
  logic                                  hwlp_err_o;

  // Drives setup/decrement/read requests and observes loop state
  modport master (
    output setback_i, hwlp_start_data_i, hwlp_end_data_i, hwlp_cnt_data_i,
           hwlp_we_i, hwlp_regid_i, valid_i, hwlp_dec_cnt_i,
           rd_req_i, rd_regid_i, rd_sel_i,
    input  rd_data_o, rd_valid_o, hwlp_start_addr_o, hwlp_end_addr_o,
           hwlp_counter_o, hwlp_active_o, hwlp_done_o, hwlp_err_o
  );

  // The loop register file itself
  modport slave (
    input  setback_i, hwlp_start_data_i, hwlp_end_data_i, hwlp_cnt_data_i,
           hwlp_we_i, hwlp_regid_i, valid_i, hwlp_dec_cnt_i,
           rd_req_i, rd_regid_i, rd_sel_i,
    output rd_data_o, rd_valid_o, hwlp_start_addr_o, hwlp_end_addr_o,
           hwlp_counter_o, hwlp_active_o, hwlp_done_o, hwlp_err_o
  );

endinterface
`default_nettype wire

// File: rtl/cv32e40p_hwloop_regs_gen.sv
`default_nettype none
// ============================================================================
//  Module   : cv32e40p_hwloop_regs_gen
//  Purpose  : Parametrised hardware-loop register file with saturating
//             counters, active/done flags, sticky error and registered CSR read.
//  Revision : 1.0  initial release
// ============================================================================
module cv32e40p_hwloop_regs_gen #(
  parameter int N_REGS     = 2,
  parameter int N_REG_BITS = (N_REGS > 1) ? $clog2(N_REGS) : 1,
  parameter int ADDR_WIDTH = 32,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  cv32e40p_hwloop_regs_gen_if.slave   bus
);

  logic [N_REGS-1:0][ADDR_WIDTH-1:0] start_q;
  logic [N_REGS-1:0][ADDR_WIDTH-1:0] end_q;
  logic [N_REGS-1:0][CNT_WIDTH-1:0]  cnt_q;
  logic [N_REGS-1:0]                 active_q;
  logic [N_REGS-1:0]                 done_q;
  logic                              err_q;
  logic [31:0]                       rd_data_q;
  logic                              rd_valid_q;

  logic [N_REGS-1:0] wr_hit;     // write targets set k (out-of-range regid hits none)
  logic [N_REGS-1:0] cnt_wr;     // counter of set k loaded this cycle
  logic [N_REGS-1:0] dec_go;     // legal decrement of set k applied this cycle
  logic [N_REGS-1:0] dec_zero;   // decrement requested on an exhausted counter
  logic              multi_dec;  // more than one decrement request at once
  logic [31:0]       rd_value;   // pre-edge value selected for the CSR read

  // Decode write target, decrement legality and CSR read mux
  always_comb begin
    wr_hit   = '0;
    cnt_wr   = '0;
    dec_go   = '0;
    dec_zero = '0;
    rd_value = '0;
    for (int k = 0; k < N_REGS; k++) begin
      wr_hit[k]   = (int'(bus.hwlp_regid_i) == k);
      cnt_wr[k]   = bus.hwlp_we_i[2] & wr_hit[k];
      dec_zero[k] = bus.valid_i & bus.hwlp_dec_cnt_i[k] & (cnt_q[k] == '0);
      dec_go[k]   = bus.valid_i & bus.hwlp_dec_cnt_i[k] & (cnt_q[k] != '0) & ~cnt_wr[k];
      if (int'(bus.rd_regid_i) == k) begin
        case (bus.rd_sel_i)
          2'd0:    rd_value = 32'(start_q[k]);
          2'd1:    rd_value = 32'(end_q[k]);
          2'd2:    rd_value = 32'(cnt_q[k]);
          default: rd_value = '0;
        endcase
      end
    end
    // The active vector is global, so the set index is irrelevant here
    if (bus.rd_sel_i == 2'd3) rd_value = 32'(active_q);
    multi_dec = bus.valid_i &
                ((bus.hwlp_dec_cnt_i & (bus.hwlp_dec_cnt_i - N_REGS'(1))) != '0);
  end

  // Loop state, error flag and read port registers
  always_ff @(posedge clk) begin
    if (rst || bus.setback_i) begin
      start_q    <= '0;
      end_q      <= '0;
      cnt_q      <= '0;
      active_q   <= '0;
      done_q     <= '0;
      err_q      <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      for (int k = 0; k < N_REGS; k++) begin
        // Addresses are halfword aligned, so bit 0 is never stored
        if (bus.hwlp_we_i[0] && wr_hit[k])
          start_q[k] <= {bus.hwlp_start_data_i[ADDR_WIDTH-1:1], 1'b0};
        if (bus.hwlp_we_i[1] && wr_hit[k])
          end_q[k] <= {bus.hwlp_end_data_i[ADDR_WIDTH-1:1], 1'b0};
        if (cnt_wr[k]) begin
          cnt_q[k]    <= bus.hwlp_cnt_data_i;
          active_q[k] <= (bus.hwlp_cnt_data_i != '0);
          done_q[k]   <= 1'b0;
        end else if (dec_go[k]) begin
          cnt_q[k] <= cnt_q[k] - CNT_WIDTH'(1);
          if (cnt_q[k] == CNT_WIDTH'(1)) begin
            active_q[k] <= 1'b0;
            done_q[k]   <= 1'b1;
          end else begin
            done_q[k]   <= 1'b0;
          end
        end else begin
          done_q[k] <= 1'b0;
        end
      end
      err_q      <= err_q | (|dec_zero) | multi_dec;
      rd_valid_q <= bus.rd_req_i;
      rd_data_q  <= bus.rd_req_i ? rd_value : 32'd0;
    end
  end

  assign bus.hwlp_start_addr_o = start_q;
  assign bus.hwlp_end_addr_o   = end_q;
  assign bus.hwlp_counter_o    = cnt_q;
  assign bus.hwlp_active_o     = active_q;
  assign bus.hwlp_done_o       = done_q;
  assign bus.hwlp_err_o        = err_q;
  assign bus.rd_data_o         = rd_data_q;
  assign bus.rd_valid_o        = rd_valid_q;

endmodule
`default_nettype wire
